// File: rtl/ring_mac_pe.sv
// Ring multiply-accumulate processing element.
// Each valid sample is forwarded to the ring successor one cycle later. It is also
// multiplied by the coefficient for its frame position and added to the accumulator.
// The last position of a frame replaces the pass-through value with the narrowed frame sum.
module ring_mac_pe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned N      = 4,
    parameter int unsigned SHIFT  = 0,
    parameter bit          SAT    = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  x_in,
    input  logic signed [DATA_W-1:0]  x_init,
    input  logic                      coef_we,
    input  logic [$clog2(N)-1:0]      coef_addr,
    input  logic signed [DATA_W-1:0]  coef_wdata,
    output logic                      out_valid,
    output logic signed [DATA_W-1:0]  y_out,
    output logic                      y_is_sum,
    output logic                      sat_hit
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   NumPos  = (IDX_W + 1)'(N);

    // Clamp bounds expressed at accumulator width so the comparison stays signed.
    localparam logic signed [ACC_W-1:0] MaxVal =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MinVal = ~MaxVal;

    logic signed [DATA_W-1:0] coef_q [N];
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] y_q;
    logic                     y_is_sum_q;
    logic                     out_valid_q;
    logic                     sat_hit_q;

    logic signed [DATA_W-1:0] coef_cur;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] narrow_val;
    logic                     narrow_sat;
    logic                     addr_ok;
    logic                     last_pos;

    // Datapath: full-precision product, accumulate, shift and narrow the frame result.
    always_comb begin
        coef_cur   = coef_q[idx_q];
        prod       = x_in * coef_cur;
        sum        = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        shifted    = sum >>> SHIFT;
        narrow_val = shifted[DATA_W-1:0];
        narrow_sat = 1'b0;
        if (SAT) begin
            if (shifted > MaxVal) begin
                narrow_val = MaxVal[DATA_W-1:0];
                narrow_sat = 1'b1;
            end else if (shifted < MinVal) begin
                narrow_val = MinVal[DATA_W-1:0];
                narrow_sat = 1'b1;
            end
        end
        addr_ok  = ({1'b0, coef_addr} < NumPos);
        last_pos = (idx_q == LastIdx);
    end

    // Coefficient bank: survives reset; out-of-range addresses are dropped.
    // The MAC reads the pre-write value in a write/read collision cycle.
    always_ff @(posedge clk) begin
        if (!reset && coef_we && addr_ok) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    // Frame sequencing: position counter, accumulator and registered ring outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            acc_q       <= '0;
            y_q         <= x_init;
            y_is_sum_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sat_hit_q   <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            sat_hit_q   <= 1'b0;
            if (in_valid) begin
                if (last_pos) begin
                    idx_q      <= '0;
                    acc_q      <= '0;
                    y_q        <= narrow_val;
                    y_is_sum_q <= 1'b1;
                    sat_hit_q  <= narrow_sat;
                end else begin
                    idx_q      <= idx_q + 1'b1;
                    acc_q      <= sum;
                    y_q        <= x_in;
                    y_is_sum_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign y_is_sum  = y_is_sum_q;
    assign sat_hit   = sat_hit_q;

endmodule

// File: tb/tb_ring_mac_pe.sv
// Directed bench for ring_mac_pe: a saturating and a wrapping instance share stimulus.
module tb_ring_mac_pe;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] x_in;
    logic signed [15:0] x_init;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_wdata;

    logic               s_out_valid, w_out_valid;
    logic signed [15:0] s_y_out, w_y_out;
    logic               s_y_is_sum, w_y_is_sum;
    logic               s_sat_hit, w_sat_hit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_mac_pe #(.DATA_W(16), .ACC_W(40), .N(4), .SHIFT(0), .SAT(1'b1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .x_init(x_init),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(s_out_valid), .y_out(s_y_out), .y_is_sum(s_y_is_sum), .sat_hit(s_sat_hit)
    );

    ring_mac_pe #(.DATA_W(16), .ACC_W(40), .N(4), .SHIFT(0), .SAT(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .x_init(x_init),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(w_out_valid), .y_out(w_y_out), .y_is_sum(w_y_is_sum), .sat_hit(w_sat_hit)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [15:0] v);
        idle();
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        step();
        coef_we = 1'b0;
    endtask

    // One valid sample; checks both instances against hand-computed results.
    task automatic send(input string tag, input logic signed [15:0] x,
                        input logic [15:0] exp_s, input logic [15:0] exp_w,
                        input logic exp_sum, input logic exp_sat);
        in_valid = 1'b1;
        x_in     = x;
        step();
        in_valid = 1'b0;
        check({tag, ".s_valid"}, {15'd0, s_out_valid}, 16'd1);
        check({tag, ".s_y"}, s_y_out, exp_s);
        check({tag, ".s_sum"}, {15'd0, s_y_is_sum}, {15'd0, exp_sum});
        check({tag, ".s_sat"}, {15'd0, s_sat_hit}, {15'd0, exp_sat});
        check({tag, ".w_y"}, w_y_out, exp_w);
        check({tag, ".w_sat"}, {15'd0, w_sat_hit}, 16'd0);
    endtask

    task automatic gap(input string tag, input logic [15:0] exp_y, input logic exp_sum);
        idle();
        step();
        check({tag, ".valid"}, {15'd0, s_out_valid}, 16'd0);
        check({tag, ".sat"}, {15'd0, s_sat_hit}, 16'd0);
        check({tag, ".y_hold"}, s_y_out, exp_y);
        check({tag, ".sum_hold"}, {15'd0, s_y_is_sum}, {15'd0, exp_sum});
    endtask

    task automatic do_reset(input logic signed [15:0] init);
        idle();
        reset  = 1'b1;
        x_init = init;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; x_in = '0; x_init = 16'h1234;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

        // Reset state
        do_reset(16'h1234);
        check("rst.y", s_y_out, 16'h1234);
        check("rst.valid", {15'd0, s_out_valid}, 16'd0);
        check("rst.sum", {15'd0, s_y_is_sum}, 16'd0);
        check("rst.sat", {15'd0, s_sat_hit}, 16'd0);
        check("rst.w_y", w_y_out, 16'h1234);

        for (int i = 0; i < 4; i++) write_coef(2'(i), 16'(i + 1));
        check("coefwr.valid", {15'd0, s_out_valid}, 16'd0);

        // Back-to-back frame: 1*1+2*2+3*3+4*4 = 30
        send("f1.0", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f1.1", 16'sd2, 16'd2, 16'd2, 1'b0, 1'b0);
        send("f1.2", 16'sd3, 16'd3, 16'd3, 1'b0, 1'b0);
        send("f1.3", 16'sd4, 16'd30, 16'd30, 1'b1, 1'b0);
        gap("f1.after", 16'd30, 1'b1);

        // Same frame with a two-cycle bubble between samples 2 and 3
        send("f2.0", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f2.1", 16'sd2, 16'd2, 16'd2, 1'b0, 1'b0);
        gap("f2.gap0", 16'd2, 1'b0);
        gap("f2.gap1", 16'd2, 1'b0);
        send("f2.2", 16'sd3, 16'd3, 16'd3, 1'b0, 1'b0);
        send("f2.3", 16'sd4, 16'd30, 16'd30, 1'b1, 1'b0);

        // Reset mid-frame discards the partial sum; coefficients survive
        send("f3.0", 16'sd7, 16'd7, 16'd7, 1'b0, 1'b0);
        send("f3.1", 16'sd9, 16'd9, 16'd9, 1'b0, 1'b0);
        // Reset wins over a coincident sample and coefficient write
        in_valid = 1'b1; x_in = 16'sd100; coef_we = 1'b1; coef_addr = 2'd1; coef_wdata = 16'sd50;
        reset = 1'b1; x_init = 16'h0000;
        step();
        idle();
        check("rst2.y", s_y_out, 16'h0000);
        check("rst2.valid", {15'd0, s_out_valid}, 16'd0);
        send("f4.0", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f4.1", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f4.2", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f4.3", 16'sd1, 16'd10, 16'd10, 1'b1, 1'b0);

        // Coefficient write colliding with idx-0 sample: old value (1) used this frame
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'sd5;
        send("f5.0", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        coef_we = 1'b0;
        send("f5.1", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f5.2", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f5.3", 16'sd1, 16'd10, 16'd10, 1'b1, 1'b0);
        // Next frame: 5+2+3+4 = 14
        send("f6.0", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f6.1", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f6.2", 16'sd1, 16'd1, 16'd1, 1'b0, 1'b0);
        send("f6.3", 16'sd1, 16'd14, 16'd14, 1'b1, 1'b0);

        // Positive overflow: 4 * 0x7FFF^2 = 0xFFFC0004
        for (int i = 0; i < 4; i++) write_coef(2'(i), 16'sh7FFF);
        send("p.0", 16'sh7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        send("p.1", 16'sh7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        send("p.2", 16'sh7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        send("p.3", 16'sh7FFF, 16'h7FFF, 16'h0004, 1'b1, 1'b1);
        gap("p.after", 16'h7FFF, 1'b1);

        // Negative overflow: 4 * (-32768 * 32767) = -0xFFFE0000, low 16 bits 0
        send("n.0", -16'sd32768, 16'h8000, 16'h8000, 1'b0, 1'b0);
        send("n.1", -16'sd32768, 16'h8000, 16'h8000, 1'b0, 1'b0);
        send("n.2", -16'sd32768, 16'h8000, 16'h8000, 1'b0, 1'b0);
        send("n.3", -16'sd32768, 16'h8000, 16'h0000, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
